// File: rtl/rom_loader.sv
// rom_loader
// ----------------------------------------------------------------------------
// Boot-time loader. It receives a byte stream and writes it into instruction
// memory as 16-bit words. The CPU is held in reset until a load completes.
//
// Stream layout:
//   N_hi N_lo              : word count N (16 bits, high byte first)
//   {W_hi W_lo} x N        : N words, high byte first
//   C                      : checksum byte (only with ROM_LOADER_CHECKSUM_EN)
//
// The checksum is the modulo-256 sum of all data bytes. Length bytes are not
// included in the sum.
//
// Build option:
//   ROM_LOADER_CHECKSUM_EN  When this macro is defined, the CSUM state and the
//                           checksum register are present. When it is
//                           undefined, the loader goes straight to DONE after
//                           the last word.
//
// Parameters:
//   SIZE      instruction memory depth in 16-bit words (SIZE <= 65536)
//
// Ports:
//   clk       sole clock; all state changes happen on its rising edge
//   rst_n     asynchronous active-low reset
//   start     one-cycle pulse; begins a session from IDLE, DONE or ERROR
//   in_data   serial byte stream
//   in_valid  in_data is valid
//   in_ready  loader can accept a byte (a transfer needs in_valid & in_ready)
//   wr_en     instruction-memory write strobe (one cycle per word)
//   wr_addr   write word address
//   wr_data   write word
//   cpu_hold  holds the CPU in reset; high in every state except DONE
//   done      load completed without error
//   error     load aborted (length too large or bad checksum)
// ----------------------------------------------------------------------------
module rom_loader #(
  parameter  int SIZE = 32768,
  localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'd5;
`endif
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  // S_TAIL is the state entered once the last word (or a zero length) has
  // been received.
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_TAIL    = S_CSUM;
`else
  localparam logic [2:0] S_TAIL    = S_DONE;
`endif

  // Length and index comparisons are done at 17 bits. This lets
  // N = SIZE = 65536 compare correctly.
  localparam logic [16:0] SIZE_W = 17'(SIZE);

  logic [2:0]    state_reg;
  logic [15:0]   len_reg;
  logic [AW:0]   idx_reg;
  logic [7:0]    hi_reg;
  logic          wr_en_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [15:0]   wr_data_reg;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_reg;
`endif

  logic        xfer;
  logic [15:0] len_next;
  logic        last_word;

  assign xfer      = in_valid & in_ready;
  // The full length is known while the low length byte is on in_data.
  assign len_next  = {len_reg[15:8], in_data};
  // The current transfer completes word idx_reg. It is the last word when
  // idx_reg + 1 reaches N.
  assign last_word = ((17'(idx_reg) + 17'd1) == {1'b0, len_reg});

`ifdef ROM_LOADER_CHECKSUM_EN
  assign in_ready = (state_reg == S_LEN_HI)  || (state_reg == S_LEN_LO) ||
                    (state_reg == S_DATA_HI) || (state_reg == S_DATA_LO) ||
                    (state_reg == S_CSUM);
`else
  assign in_ready = (state_reg == S_LEN_HI)  || (state_reg == S_LEN_LO) ||
                    (state_reg == S_DATA_HI) || (state_reg == S_DATA_LO);
`endif

  assign cpu_hold = (state_reg != S_DONE);
  assign done     = (state_reg == S_DONE);
  assign error    = (state_reg == S_ERROR);
  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      len_reg     <= '0;
      idx_reg     <= '0;
      hi_reg      <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_reg    <= '0;
`endif
    end else begin
      // The write strobe lasts one cycle. Address and data keep their
      // last values after the strobe drops.
      wr_en_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_reg <= S_LEN_HI;
            len_reg   <= '0;
            idx_reg   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_reg  <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_reg[15:8] <= in_data;
            state_reg     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_reg[7:0] <= in_data;
            if ({1'b0, len_next} > SIZE_W)
              state_reg <= S_ERROR;
            else if (len_next == 16'd0)
              state_reg <= S_TAIL;
            else
              state_reg <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            hi_reg    <= in_data;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_reg  <= csum_reg + in_data;
`endif
            state_reg <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= idx_reg[AW-1:0];
            wr_data_reg <= {hi_reg, in_data};
            idx_reg     <= idx_reg + 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_reg    <= csum_reg + in_data;
`endif
            state_reg   <= last_word ? S_TAIL : S_DATA_HI;
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer)
            state_reg <= (in_data == csum_reg) ? S_DONE : S_ERROR;
        end
`endif
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
// ----------------------------------------------------------------------------
// Directed testbench for rom_loader, instantiated with SIZE = 4.
// A table of whole load sessions is applied in a loop. Each session checks
// the logged writes and the final status outputs. Hand-written sequences
// then cover reset behaviour, the idle ignore, back-to-back timing, start
// while busy, and reset in the middle of a load.
// When ROM_LOADER_CHECKSUM_EN is defined, the bench sends a checksum byte.
// ----------------------------------------------------------------------------
module tb_rom_loader;

  localparam int SIZE = 4;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          cpu_hold;
  logic          done;
  logic          error;

  rom_loader #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Write log, sampled mid-cycle. Each wr_en pulse lasts one cycle, so each
  // pulse is logged once.
  int            wcount = 0;
  logic [AW-1:0] waddr_log [64];
  logic [15:0]   wdata_log [64];

  always @(negedge clk) begin
    if (wr_en) begin
      if (wcount < 64) begin
        waddr_log[wcount] = wr_addr;
        wdata_log[wcount] = wr_data;
      end
      wcount = wcount + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Tasks start and end at 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte and wait (bounded) until it is taken. With toggle set,
  // in_valid then drops for one cycle.
  task automatic send_byte(input logic [7:0] b, input logic toggle);
    bit ok;
    ok       = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    if (toggle) begin
      in_valid = 1'b0;
      tick();
    end
  endtask

  typedef struct packed {
    logic [0:9][7:0]  b;         // stream bytes, length first
    logic [3:0]       nb;        // number of stream bytes (no checksum)
    logic             toggle;    // in_valid toggles between bytes
    logic             len_err;   // aborts on length: no checksum byte sent
    logic             bad_csum;  // corrupt the checksum byte
    logic [2:0]       nw;        // expected number of writes
    logic [0:3][15:0] wd;        // expected write data, addresses 0..nw-1
    logic             exp_done;
    logic             exp_err;
  } vec_t;

  vec_t vec [8];
  int   nvec;

`ifdef ROM_LOADER_CHECKSUM_EN
  function automatic logic [7:0] csum_of(input vec_t x);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 2; k < 10; k++)
      if (k < int'(x.nb)) s = s + x.b[k];
    return s;
  endfunction
`endif

  initial begin
    int base;
    logic [7:0] bb [6];

    vec[0] = '{b:80'h0002_1234_ABCD_0000_0000, nb:4'd6, toggle:1'b0, len_err:1'b0, bad_csum:1'b0,
               nw:3'd2, wd:64'h1234_ABCD_0000_0000, exp_done:1'b1, exp_err:1'b0};
    vec[1] = '{b:80'h0002_1234_ABCD_0000_0000, nb:4'd6, toggle:1'b1, len_err:1'b0, bad_csum:1'b0,
               nw:3'd2, wd:64'h1234_ABCD_0000_0000, exp_done:1'b1, exp_err:1'b0};
    vec[2] = '{b:80'h0005_0000_0000_0000_0000, nb:4'd2, toggle:1'b0, len_err:1'b1, bad_csum:1'b0,
               nw:3'd0, wd:64'h0, exp_done:1'b0, exp_err:1'b1};
    vec[3] = '{b:80'h0000_0000_0000_0000_0000, nb:4'd2, toggle:1'b0, len_err:1'b0, bad_csum:1'b0,
               nw:3'd0, wd:64'h0, exp_done:1'b1, exp_err:1'b0};
    vec[4] = '{b:80'h0004_0102_0304_0506_0708, nb:4'd10, toggle:1'b0, len_err:1'b0, bad_csum:1'b0,
               nw:3'd4, wd:64'h0102_0304_0506_0708, exp_done:1'b1, exp_err:1'b0};
    vec[5] = '{b:80'h0100_0000_0000_0000_0000, nb:4'd2, toggle:1'b0, len_err:1'b1, bad_csum:1'b0,
               nw:3'd0, wd:64'h0, exp_done:1'b0, exp_err:1'b1};
    vec[6] = '{b:80'h0003_FFFF_8000_0001_0000, nb:4'd8, toggle:1'b1, len_err:1'b0, bad_csum:1'b0,
               nw:3'd3, wd:64'hFFFF_8000_0001_0000, exp_done:1'b1, exp_err:1'b0};
    nvec = 7;
`ifdef ROM_LOADER_CHECKSUM_EN
    vec[7] = '{b:80'h0002_1234_ABCD_0000_0000, nb:4'd6, toggle:1'b0, len_err:1'b0, bad_csum:1'b1,
               nw:3'd2, wd:64'h1234_ABCD_0000_0000, exp_done:1'b0, exp_err:1'b1};
    nvec = 8;
`endif

    // ---------------- reset state ----------------
    rst_n    = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en",    wr_en,    0);
    check("rst_wr_addr",  wr_addr,  0);
    check("rst_wr_data",  wr_data,  0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done",     done,     0);
    check("rst_error",    error,    0);
    rst_n = 1'b1;
    tick();

    // ---------------- bytes offered in IDLE are ignored ----------------
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick();
    check("idle_in_ready", in_ready, 0);
    check("idle_done",     done,     0);
    check("idle_hold",     cpu_hold, 1);
    in_valid = 1'b0;
    $display("idle ignore: in_ready=%0b done=%0b", in_ready, done);

    // ---------------- table of load sessions ----------------
    for (int v = 0; v < nvec; v++) begin
      base = wcount;
      pulse_start();
      check("start_done_clr",  done,     0);
      check("start_error_clr", error,    0);
      check("start_ready",     in_ready, 1);
      for (int k = 0; k < int'(vec[v].nb); k++)
        send_byte(vec[v].b[k], vec[v].toggle);
`ifdef ROM_LOADER_CHECKSUM_EN
      if (!vec[v].len_err)
        send_byte(csum_of(vec[v]) + {7'd0, vec[v].bad_csum}, vec[v].toggle);
`endif
      in_valid = 1'b0;
      repeat (2) tick();
      check("vec_nwrites", wcount - base, {29'd0, vec[v].nw});
      for (int i = 0; i < int'(vec[v].nw); i++) begin
        check("vec_addr", {30'd0, waddr_log[base+i]}, i);
        check("vec_data", {16'd0, wdata_log[base+i]}, {16'd0, vec[v].wd[i]});
      end
      check("vec_done",     done,     vec[v].exp_done);
      check("vec_error",    error,    vec[v].exp_err);
      check("vec_hold",     cpu_hold, !vec[v].exp_done);
      check("vec_in_ready", in_ready, 0);
      check("vec_wr_en",    wr_en,    0);
      $display("vec %0d: writes=%0d done=%0b error=%0b hold=%0b",
               v, wcount - base, done, error, cpu_hold);
    end

    // ------- back-to-back bytes, one per cycle, start ignored when busy -------
    bb[0] = 8'h00; bb[1] = 8'h02; bb[2] = 8'h12;
    bb[3] = 8'h34; bb[4] = 8'hAB; bb[5] = 8'hCD;
    base = wcount;
    pulse_start();
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("b2b_ready", in_ready, 1);
      in_data = bb[k];
      start   = (k == 2);
      tick();
    end
    start = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
    check("b2b_ready_csum", in_ready, 1);
    in_data = 8'hBE;
    tick();
`endif
    in_valid = 1'b0;
    check("b2b_done_now", done, 1);
    tick();
    check("b2b_nwrites", wcount - base, 2);
    check("b2b_data0",   {16'd0, wdata_log[base]}, 32'h1234);
    check("b2b_data1",   {16'd0, wdata_log[base+1]}, 32'hABCD);
    $display("back-to-back: writes=%0d done=%0b", wcount - base, done);

    // ---------------- reset in the middle of a load ----------------
    base = wcount;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en",    wr_en,    0);
    check("mid_rst_wr_addr",  wr_addr,  0);
    check("mid_rst_wr_data",  wr_data,  0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_hold",     cpu_hold, 1);
    check("mid_rst_done",     done,     0);
    check("mid_rst_error",    error,    0);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAB;
    repeat (4) tick();
    in_valid = 1'b0;
    check("post_rst_nwrites", wcount - base, 1);
    check("post_rst_ready",   in_ready, 0);
    check("post_rst_done",    done,     0);
    $display("mid-load reset: writes=%0d in_ready=%0b", wcount - base, in_ready);

    // ---------------- fresh load after reset ----------------
    base = wcount;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
`ifdef ROM_LOADER_CHECKSUM_EN
    send_byte(8'hAD, 1'b0);
`endif
    in_valid = 1'b0;
    repeat (2) tick();
    check("fresh_nwrites", wcount - base, 1);
    check("fresh_addr",    {30'd0, waddr_log[base]}, 0);
    check("fresh_data",    {16'd0, wdata_log[base]}, 32'hBEEF);
    check("fresh_done",    done, 1);
    check("fresh_hold",    cpu_hold, 0);
    $display("fresh load: writes=%0d done=%0b", wcount - base, done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

endmodule
